// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a 2W-bit result accumulator and a
// shift-and-add multiplier that takes W cycles.
//
// Ports:
//   clock    rising-edge clock for all state
//   reset_n  synchronous active-low reset
//   start    launch request, accepted only while busy is low
//   op       operation select (3 bits), sampled on an accepted start
//   a        operand A (W bits), sampled on an accepted start
//   b        operand B (W bits) when use_acc is low
//   use_acc  1 selects acc[W-1:0] as operand B instead of b
//   acc      2W-bit result register
//   busy     high while a multiply is in progress
//   done     one-cycle pulse: acc was written on the previous edge
module alu_seq #(
   parameter int W = 4
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           start,
   input  logic [2:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           use_acc,
   output logic [2*W-1:0] acc,
   output logic           busy,
   output logic           done
);

   localparam int AW = 2 * W;
   localparam int CW = $clog2(W);

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_LOGIC = 3'b010;
   localparam logic [2:0] OP_ORR   = 3'b011;
   localparam logic [2:0] OP_ANDR  = 3'b100;
   localparam logic [2:0] OP_SHL   = 3'b101;
   localparam logic [2:0] OP_SHR   = 3'b110;
   localparam logic [2:0] OP_MUL   = 3'b111;

   typedef enum logic {
      IDLE,
      MUL
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [AW-1:0]   acc_next;
   logic            done_next;
   logic [AW-1:0]   mcand;
   logic [AW-1:0]   mcand_next;
   logic [W-1:0]    mplier;
   logic [W-1:0]    mplier_next;
   logic [AW-1:0]   prod;
   logic [AW-1:0]   prod_next;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;
   logic [W-1:0]    b_sel;
   logic [AW-1:0]   a_ext;
   logic [AW-1:0]   b_ext;
   logic [AW-1:0]   result;

   // Single-cycle result path. Operand B feeds back only the low half of
   // the accumulator. Shifting by a W-bit amount that exceeds the operand
   // width yields zero on its own, so no explicit range check is needed.
   always_comb begin
      b_sel  = use_acc ? acc[W-1:0] : b;
      a_ext  = AW'(a);
      b_ext  = AW'(b_sel);
      result = '0;
      case (op)
         OP_ADD:   result = a_ext + b_ext;
         OP_SUB:   result = a_ext - b_ext;
         OP_LOGIC: result = {a | b_sel, a ^ b_sel};
         OP_ORR:   result = AW'(|{a, b_sel});
         OP_ANDR:  result = AW'(&{a, b_sel});
         OP_SHL:   result = b_ext << a;
         OP_SHR:   result = b_ext >> a;
         OP_MUL:   result = '0;
         default:  result = '0;
      endcase
   end

   // Next-state and output logic. In MUL the multiplicand shifts left and
   // the multiplier shifts right each step, so bit 0 of the multiplier is
   // always the bit being processed. The last step writes the accumulator
   // with the sum that includes that step's partial product.
   always_comb begin
      state_next  = state;
      acc_next    = acc;
      done_next   = 1'b0;
      mcand_next  = mcand;
      mplier_next = mplier;
      prod_next   = prod;
      count_next  = count;
      busy        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (op == OP_MUL) begin
                  mcand_next  = a_ext;
                  mplier_next = b_sel;
                  prod_next   = '0;
                  count_next  = '0;
                  state_next  = MUL;
               end else begin
                  acc_next  = result;
                  done_next = 1'b1;
               end
            end
         end
         MUL: begin
            busy = 1'b1;
            if (mplier[0]) begin
               prod_next = prod + mcand;
            end
            mcand_next  = mcand << 1;
            mplier_next = mplier >> 1;
            count_next  = count + 1'b1;
            if (count == CW'(W - 1)) begin
               acc_next   = prod_next;
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register. Reset wins over any start in the same cycle and
   // abandons a multiply in flight without producing a done pulse.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state  <= IDLE;
         acc    <= '0;
         done   <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         count  <= '0;
      end else begin
         state  <= state_next;
         acc    <= acc_next;
         done   <= done_next;
         mcand  <= mcand_next;
         mplier <= mplier_next;
         prod   <= prod_next;
         count  <= count_next;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (W=4). A cycle-level
// behavioural model predicts acc/busy/done after every edge and is compared
// against the DUT each cycle; directed steps also check hand-computed values.
module tb_alu_seq;

   localparam int W  = 4;
   localparam int AW = 2 * W;

   logic          clock;
   logic          reset_n;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          use_acc;
   logic [AW-1:0] acc;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   alu_seq #(.W(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .use_acc (use_acc),
      .acc     (acc),
      .busy    (busy),
      .done    (done)
   );

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference result of a single-cycle op, straight from the arithmetic rules.
   function automatic logic [AW-1:0] refOp(input logic [2:0] o, input longint x, input longint y);
      longint mask;
      longint all1;
      longint r;
      mask = (longint'(1) << AW) - 1;
      all1 = (longint'(1) << W) - 1;
      case (o)
         3'd0:    r = x + y;
         3'd1:    r = x - y;
         3'd2:    r = ((x | y) << W) | (x ^ y);
         3'd3:    r = (x != 0 || y != 0) ? 1 : 0;
         3'd4:    r = (x == all1 && y == all1) ? 1 : 0;
         3'd5:    r = (x >= AW) ? 0 : (y << x);
         3'd6:    r = (x >= W) ? 0 : (y >> x);
         default: r = x * y;
      endcase
      return AW'(r & mask);
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs at the falling edge and waits for the next
   // falling edge, by which time the rising edge in between has sampled them.
   task automatic applyStimulus(input logic rn, input logic st, input logic [2:0] o,
                                input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ua);
      reset_n = rn;
      start   = st;
      op      = o;
      a       = aa;
      b       = bb;
      use_acc = ua;
      @(negedge clock);
   endtask

   // Behavioural model plus per-cycle compare.
   logic [AW-1:0] m_acc  = '0;
   logic          m_busy = 1'b0;
   logic          m_done = 1'b0;
   logic [AW-1:0] m_res  = '0;
   int            m_left = 0;
   logic          m_valid = 1'b0;

   always @(posedge clock) begin
      logic [W-1:0] bs;
      if (!reset_n) begin
         m_acc   = '0;
         m_busy  = 1'b0;
         m_done  = 1'b0;
         m_left  = 0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         m_done = 1'b0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_acc  = m_res;
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end else if (start) begin
            bs = use_acc ? m_acc[W-1:0] : b;
            if (op == 3'd7) begin
               m_res  = AW'(longint'(a) * longint'(bs));
               m_busy = 1'b1;
               m_left = W;
            end else begin
               m_acc  = refOp(op, longint'(a), longint'(bs));
               m_done = 1'b1;
            end
         end
      end
      #1;
      if (m_valid) begin
         checkOutput("model_acc",  longint'(acc),  longint'(m_acc));
         checkOutput("model_busy", longint'(busy), longint'(m_busy));
         checkOutput("model_done", longint'(done), longint'(m_done));
      end
   end

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 3'd0;
      a       = '0;
      b       = '0;
      use_acc = 1'b0;
      @(negedge clock);
      applyStimulus(1'b0, 1'b1, 3'd0, 4'h3, 4'h3, 1'b0);
      checkOutput("reset_acc",  longint'(acc),  0);
      checkOutput("reset_busy", longint'(busy), 0);
      checkOutput("reset_done", longint'(done), 0);

      // ADD and the one-cycle done pulse.
      applyStimulus(1'b1, 1'b1, 3'd0, 4'h9, 4'h8, 1'b0);
      checkOutput("add_acc",  longint'(acc),  'h11);
      checkOutput("add_done", longint'(done), 1);
      checkOutput("add_busy", longint'(busy), 0);
      applyStimulus(1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0);
      checkOutput("add_done_fall", longint'(done), 0);
      checkOutput("add_acc_hold",  longint'(acc),  'h11);

      // Single-cycle ops back to back.
      applyStimulus(1'b1, 1'b1, 3'd2, 4'hA, 4'h6, 1'b0);
      checkOutput("logic_acc", longint'(acc), 'hEC);
      applyStimulus(1'b1, 1'b1, 3'd1, 4'h2, 4'h3, 1'b0);
      checkOutput("sub_acc", longint'(acc), 'hFF);
      applyStimulus(1'b1, 1'b1, 3'd5, 4'h3, 4'hF, 1'b0);
      checkOutput("shl_acc", longint'(acc), 'h78);
      applyStimulus(1'b1, 1'b1, 3'd5, 4'h9, 4'hF, 1'b0);
      checkOutput("shl_big_acc", longint'(acc), 'h00);
      applyStimulus(1'b1, 1'b1, 3'd6, 4'h1, 4'hC, 1'b0);
      checkOutput("shr_acc", longint'(acc), 'h06);

      // MUL with inputs toggling and start pulsed during the operation.
      applyStimulus(1'b1, 1'b1, 3'd7, 4'hF, 4'hF, 1'b0);
      checkOutput("mul_busy_start", longint'(busy), 1);
      checkOutput("mul_acc_hold",   longint'(acc),  'h06);
      for (int i = 0; i < W; i++) begin
         applyStimulus(1'b1, 1'b1, 3'($urandom_range(0, 6)), 4'($urandom), 4'($urandom), 1'($urandom));
      end
      checkOutput("mul_acc",  longint'(acc),  'hE1);
      checkOutput("mul_done", longint'(done), 1);
      checkOutput("mul_busy_end", longint'(busy), 0);
      applyStimulus(1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0);
      checkOutput("mul_done_fall", longint'(done), 0);

      // Accumulate chain from reset.
      applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 1'b1, 3'd0, 4'h1, 4'h0, 1'b1);
         checkOutput("chain_acc",  longint'(acc),  i);
         checkOutput("chain_done", longint'(done), 1);
      end

      // Reset in the second MUL cycle, then a clean MUL.
      applyStimulus(1'b1, 1'b1, 3'd7, 4'h7, 4'h5, 1'b0);
      applyStimulus(1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0);
      checkOutput("abort_acc",  longint'(acc),  0);
      checkOutput("abort_busy", longint'(busy), 0);
      for (int i = 0; i < W + 1; i++) begin
         applyStimulus(1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0);
         checkOutput("abort_no_done", longint'(done), 0);
      end
      applyStimulus(1'b1, 1'b1, 3'd7, 4'h7, 4'h5, 1'b0);
      for (int i = 0; i < W; i++) begin
         applyStimulus(1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0);
      end
      checkOutput("mul2_acc", longint'(acc), 'h23);

      // Reductions.
      applyStimulus(1'b1, 1'b1, 3'd3, 4'h0, 4'h0, 1'b0);
      checkOutput("orr_zero", longint'(acc), 0);
      applyStimulus(1'b1, 1'b1, 3'd3, 4'h0, 4'h1, 1'b0);
      checkOutput("orr_one", longint'(acc), 1);
      applyStimulus(1'b1, 1'b1, 3'd4, 4'hF, 4'hF, 1'b0);
      checkOutput("andr_one", longint'(acc), 1);
      applyStimulus(1'b1, 1'b1, 3'd4, 4'hF, 4'hE, 1'b0);
      checkOutput("andr_zero", longint'(acc), 0);

      // Randomised traffic with occasional resets, checked by the model.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 3) != 0),
                       3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      end

      applyStimulus(1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
